fsm_bit_serializer: RTL and testbench

- Upstream feeder for the 1011010 Mealy sequence detector.
- Accepts parallel words over a valid/ready handshake and emits them one bit per accepted cycle, MSB-first, on a serial valid/ready stream.
- Its serial output drives the detector's `in`; downstream logic advances the detector only on cycles where `ser_valid && ser_ready`.
- Words may stream back-to-back with no gap bit between them.

---
 rtl/fsm_seq_pkg.sv | 14 +
 rtl/fsm_bit_serializer.sv | 95 +++++++++
 tb/tb_fsm_bit_serializer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fsm_seq_pkg.sv
// Shared types and constants for the 1011010 sequence-detector slice.
// Used by the bit serializer, the detector and their benches.
package fsm_seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [6:0] DET_PATTERN = 7'b1011010;

endpackage : fsm_seq_pkg

// File: rtl/fsm_bit_serializer.sv
// Parallel-to-serial feeder: valid/ready word in, one bit per accepted cycle out.
// MSB-first by default; define SER_LSB_FIRST_EN for LSB-first output.
module fsm_bit_serializer
  import fsm_seq_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             word_done,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last, xfer, accept;

  assign ser_valid = (state_q == SHIFT);
  assign busy      = ser_valid;
  assign last      = (cnt_q == LAST_CNT);
  assign xfer      = ser_valid && ser_ready;
  assign word_done = xfer && last;
  // Reset gates in_ready so no word is acknowledged while reset is held.
  assign in_ready  = reset && ((state_q == IDLE) || (last && xfer));
  assign accept    = in_valid && in_ready;

`ifdef SER_LSB_FIRST_EN
  assign ser_bit = shreg_q[0];
`else
  assign ser_bit = shreg_q[WIDTH-1];
`endif

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path
    // through the case leaves one unassigned, which would infer a latch.
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = in_data;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (!last) begin
`ifdef SER_LSB_FIRST_EN
            shreg_d = shreg_q >> 1;
`else
            shreg_d = shreg_q << 1;
`endif
            cnt_d = cnt_q + CNT_W'(1);
          end else if (accept) begin
            // Chain the next word on the same edge: no gap bit between words.
            shreg_d = in_data;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : fsm_bit_serializer

// File: tb/tb_fsm_bit_serializer.sv
// Directed bench for fsm_bit_serializer: table-driven single/back-to-back words,
// hand sequences for backpressure and mid-word reset. Honors SER_LSB_FIRST_EN.
module tb_fsm_bit_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ser_bit;
  logic       ser_valid;
  logic       ser_ready;
  logic       word_done;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       iv;
    logic [7:0] data;
    logic       sr;
    logic       exp_bit;
    logic       exp_valid;
    logic       exp_ready;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];

  // Expected serial order of each word, first bit in position 7.
`ifdef SER_LSB_FIRST_EN
  logic [7:0] s_b4 = 8'b0010_1101;
  logic [7:0] s_5a = 8'b0101_1010;
  logic [7:0] s_a5 = 8'b1010_0101;
  logic [7:0] s_01 = 8'b1000_0000;
`else
  logic [7:0] s_b4 = 8'b1011_0100;
  logic [7:0] s_5a = 8'b0101_1010;
  logic [7:0] s_a5 = 8'b1010_0101;
  logic [7:0] s_01 = 8'b0000_0001;
`endif

  fsm_bit_serializer dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ser_bit   (ser_bit),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .word_done (word_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic add(input logic iv, input logic [7:0] d, input logic sr,
                     input logic eb, input logic ev, input logic er, input logic ed);
    vec_t v;
    v.iv = iv; v.data = d; v.sr = sr;
    v.exp_bit = eb; v.exp_valid = ev; v.exp_ready = er; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs on the falling edge, then compare all outputs.
  task automatic step(input logic iv, input logic [7:0] d, input logic sr,
                      input logic eb, input logic ev, input logic er, input logic ed,
                      input string tag);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    ser_ready = sr;
    #1;
    check({tag, " ser_bit"},   32'(ser_bit),   32'(eb));
    check({tag, " ser_valid"}, 32'(ser_valid), 32'(ev));
    check({tag, " busy"},      32'(busy),      32'(ev));
    check({tag, " in_ready"},  32'(in_ready),  32'(er));
    check({tag, " word_done"}, 32'(word_done), 32'(ed));
  endtask

  initial begin
    int k;
    logic sr;

    // Single word 0xB4.
    add(1'b1, 8'hB4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      add(1'b0, 8'h00, 1'b1, s_b4[7-i], 1'b1, i == 7, i == 7);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    // Back-to-back 0xB4 then 0x5A with in_valid held: 16 bits, no gap.
    add(1'b1, 8'hB4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      add(1'b1, 8'h5A, 1'b1, s_b4[7-i], 1'b1, i == 7, i == 7);
    for (int i = 0; i < 8; i++)
      add(1'b0, 8'h00, 1'b1, s_5a[7-i], 1'b1, i == 7, i == 7);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset held for 3 cycles with in_valid asserted.
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hC3;
    ser_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      step(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("release in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].iv, vecs[i].data, vecs[i].sr, vecs[i].exp_bit,
           vecs[i].exp_valid, vecs[i].exp_ready, vecs[i].exp_done,
           $sformatf("vec%0d", i));

    // Backpressure on 0xA5: ser_ready follows 1,0,0,1,... ; bit holds on stalls.
    step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "bp accept");
    k = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      sr = (c % 4 == 0) || (c % 4 == 3);
      step(1'b0, 8'h00, sr, s_a5[7-k], 1'b1, sr && k == 7, sr && k == 7,
           $sformatf("bp c%0d", c));
      if (sr) k++;
    end
    check("bp transfers", 32'(k), 32'd8);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "bp idle");

    // Reset after 3 bits of 0xFF: word discarded, then 0x01 serializes cleanly.
    step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "mid accept");
    for (int i = 0; i < 3; i++)
      step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "mid bits");
    @(negedge clk);
    in_valid  = 1'b0;
    ser_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("mid rst ser_valid", 32'(ser_valid), 32'd0);
    check("mid rst ser_bit",   32'(ser_bit),   32'd0);
    check("mid rst word_done", 32'(word_done), 32'd0);
    check("mid rst in_ready",  32'(in_ready),  32'd0);
    for (int i = 0; i < 2; i++)
      step(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "mid hold");
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    step(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "post accept");
    for (int i = 0; i < 8; i++)
      step(1'b0, 8'h00, 1'b1, s_01[7-i], 1'b1, i == 7, i == 7, $sformatf("post b%0d", i));
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "post idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fsm_bit_serializer
